// File: rtl/lat_table_loader_if.sv
// Host-side bundle for the LAT jump-table loader: load request, table contents,
// SIPO handshake and the loader's serial/status outputs.
interface lat_table_loader_if #(
  parameter int JW = 5
);
  logic          start;
  logic [JW-1:0] jump1;
  logic [JW-1:0] jump2;
  logic [JW-1:0] jump3;
  logic [JW-1:0] jump4;
  logic [JW-1:0] jump5;
  logic          clk_sel_i;
  logic          out_sel_i;
  logic          finished;
  logic          ser_out;
  logic          ser_en;
  logic          fsm_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    retry_cnt;

  modport master (
    output start, jump1, jump2, jump3, jump4, jump5, clk_sel_i, out_sel_i, finished,
    input  ser_out, ser_en, fsm_hold, busy, done, error, retry_cnt
  );

  modport slave (
    input  start, jump1, jump2, jump3, jump4, jump5, clk_sel_i, out_sel_i, finished,
    output ser_out, ser_en, fsm_hold, busy, done, error, retry_cnt
  );
endinterface

// File: rtl/lat_table_loader.sv
// Programs the LAT table FSM jump table: captures one frame on start, shifts it MSB-first
// to the SIPO config register and waits for its finished flag, resending on timeout.
module lat_table_loader #(
  parameter int JW          = 5,
  parameter int FRAME_W     = 2 + 5 * JW,
  parameter int ACK_TIMEOUT = 31,
  parameter int MAX_RETRY   = 2
) (
  input logic               clk,
  input logic               rst,
  lat_table_loader_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_W);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [1:0]       MAX_R   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [1:0]         retry_q;
  logic               ser_out_q;
  logic               ser_en_q;
  logic               hold_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  // Frame order on the wire: out_sel first, jump5[0] last.
  assign frame_d = {bus.out_sel_i, bus.clk_sel_i,
                    bus.jump1, bus.jump2, bus.jump3, bus.jump4, bus.jump5};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      retry_q   <= '0;
      ser_out_q <= 1'b0;
      ser_en_q  <= 1'b0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            frame_q <= frame_d;
            retry_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          hold_q    <= 1'b1;
          cnt_q     <= CNT_TOP;
          ser_en_q  <= 1'b1;
          ser_out_q <= frame_q[CNT_TOP];
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          // cnt_q indexes the bit currently on ser_out; the next one is preloaded here.
          if (cnt_q == '0) begin
            ser_en_q  <= 1'b0;
            ser_out_q <= 1'b0;
            tmr_q     <= '0;
            state_q   <= S_WAIT_ACK;
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            ser_out_q <= frame_q[cnt_q - CNT_ONE];
          end
        end
        S_WAIT_ACK: begin
          // finished takes priority over a timeout landing in the same cycle.
          if (bus.finished) begin
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (tmr_q == TMR_TOP) begin
            if (retry_q < MAX_R) begin
              retry_q <= retry_q + 2'd1;
              state_q <= S_LOAD;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_en    = ser_en_q;
  assign bus.fsm_hold  = hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;
  assign bus.retry_cnt = retry_q;
endmodule
